// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state, source codes and width constants for the acquisition sequencer
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_WAIT_SYNC,
        ST_CAPTURE,
        ST_FINISH
    } acq_state_t;

    localparam logic [1:0] SRC_SIM      = 2'd0;
    localparam logic [1:0] SRC_ADC_HS   = 2'd1;
    localparam logic [1:0] SRC_ADC_2308 = 2'd2;
    localparam logic [1:0] SRC_INVALID  = 2'd3;

    localparam int DATA_W     = 32;
    localparam int ADC_HS_W   = 14;
    localparam int ADC_HS_PAD = DATA_W - ADC_HS_W;

endpackage

// File: rtl/acq_source_mux.sv
// rtl/acq_source_mux.sv - selects one input stream by source code and registers the output beat
module acq_source_mux
    import acq_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          src,
    input  logic                emit,
    input  logic [DATA_W-1:0]   sim_data,
    input  logic                sim_valid,
    input  logic [ADC_HS_W-1:0] adc_hs_data,
    input  logic                adc_hs_valid,
    input  logic [DATA_W-1:0]   adc2308_data,
    input  logic                adc2308_valid,
    output logic                sel_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_out_valid
);

    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        case (src)
            SRC_SIM: begin
                sel_data  = sim_data;
                sel_valid = sim_valid;
            end
            SRC_ADC_HS: begin
                sel_data  = {{ADC_HS_PAD{1'b0}}, adc_hs_data};
                sel_valid = adc_hs_valid;
            end
            SRC_ADC_2308: begin
                sel_data  = adc2308_data;
                sel_valid = adc2308_valid;
            end
            default: ;
        endcase
    end

    // emit is only raised by the sequencer when sel_valid is set in CAPTURE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= emit;
            if (emit) begin
                data_out <= sel_data;
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - acquisition controller: skip, optional sync wait, and framed capture of N samples
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int SKIP_W = 16
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          source_sel,
    input  logic [CNT_W-1:0]    n_samples,
    input  logic [SKIP_W-1:0]   skip_samples,
    input  logic                sync_mode,
    input  logic                sync_in,
    input  logic [CNT_W-1:0]    sync_timeout,
    input  logic [DATA_W-1:0]   sim_data,
    input  logic                sim_valid,
    input  logic [ADC_HS_W-1:0] adc_hs_data,
    input  logic                adc_hs_valid,
    input  logic [DATA_W-1:0]   adc2308_data,
    input  logic                adc2308_valid,
    output logic                src_enable,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_out_valid,
    output logic                sop,
    output logic                eop,
    output logic                busy,
    output logic                done,
    output logic                timeout_flag,
    output logic                abort_flag,
    output logic                sel_error
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SKIP_W-1:0] SKIP_ONE = {{(SKIP_W-1){1'b0}}, 1'b1};

    acq_state_t        state;
    logic [1:0]        src_r;
    logic [CNT_W-1:0]  n_r;
    logic [CNT_W-1:0]  tmo_r;
    logic [CNT_W-1:0]  smp_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  tmo_next;
    logic [SKIP_W-1:0] skip_r;
    logic [SKIP_W-1:0] skip_cnt;
    logic              sync_mode_r;
    logic              sync_r;
    logic              sync_prev;
    logic              sync_edge;
    logic              fin_last;
    logic              sel_valid;
    logic              emit;

    assign emit      = (state == ST_CAPTURE) && sel_valid && !abort;
    assign sync_edge = sync_r && !sync_prev;
    assign tmo_next  = (&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_ONE;

    acq_source_mux u_mux (
        .clk            (clk),
        .reset_n        (reset_n),
        .src            (src_r),
        .emit           (emit),
        .sim_data       (sim_data),
        .sim_valid      (sim_valid),
        .adc_hs_data    (adc_hs_data),
        .adc_hs_valid   (adc_hs_valid),
        .adc2308_data   (adc2308_data),
        .adc2308_valid  (adc2308_valid),
        .sel_valid      (sel_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            src_r        <= SRC_SIM;
            n_r          <= '0;
            tmo_r        <= '0;
            skip_r       <= '0;
            sync_mode_r  <= 1'b0;
            smp_cnt      <= '0;
            tmo_cnt      <= '0;
            skip_cnt     <= '0;
            sync_r       <= 1'b0;
            sync_prev    <= 1'b0;
            fin_last     <= 1'b0;
            src_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sop          <= 1'b0;
            eop          <= 1'b0;
            timeout_flag <= 1'b0;
            abort_flag   <= 1'b0;
            sel_error    <= 1'b0;
        end else begin
            sync_r    <= sync_in;
            sync_prev <= sync_r;
            done      <= 1'b0;
            sop       <= 1'b0;
            eop       <= 1'b0;
            // abort beats everything, including a final valid or the done pulse
            if (state != ST_IDLE && abort) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                src_enable <= 1'b0;
                fin_last   <= 1'b0;
                abort_flag <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (source_sel == SRC_INVALID) begin
                                sel_error <= 1'b1;
                            end else begin
                                src_r        <= source_sel;
                                n_r          <= n_samples;
                                skip_r       <= skip_samples;
                                sync_mode_r  <= sync_mode;
                                tmo_r        <= sync_timeout;
                                smp_cnt      <= '0;
                                tmo_cnt      <= '0;
                                skip_cnt     <= '0;
                                timeout_flag <= 1'b0;
                                abort_flag   <= 1'b0;
                                sel_error    <= 1'b0;
                                busy         <= 1'b1;
                                if (n_samples == '0) begin
                                    state      <= ST_FINISH;
                                    src_enable <= 1'b0;
                                end else begin
                                    src_enable <= 1'b1;
                                    if (skip_samples != '0) begin
                                        state <= ST_SKIP;
                                    end else begin
                                        state <= sync_mode ? ST_WAIT_SYNC : ST_CAPTURE;
                                    end
                                end
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (sel_valid) begin
                            if (skip_cnt + SKIP_ONE == skip_r) begin
                                state <= sync_mode_r ? ST_WAIT_SYNC : ST_CAPTURE;
                            end else begin
                                skip_cnt <= skip_cnt + SKIP_ONE;
                            end
                        end
                    end
                    ST_WAIT_SYNC: begin
                        if (sync_edge) begin
                            state <= ST_CAPTURE;
                        end else if (tmo_r != '0 && tmo_next == tmo_r) begin
                            timeout_flag <= 1'b1;
                            src_enable   <= 1'b0;
                            state        <= ST_FINISH;
                        end else begin
                            tmo_cnt <= tmo_next;
                        end
                    end
                    ST_CAPTURE: begin
                        if (sel_valid) begin
                            smp_cnt <= smp_cnt + CNT_ONE;
                            sop     <= (smp_cnt == '0);
                            if (smp_cnt + CNT_ONE == n_r) begin
                                eop        <= 1'b1;
                                src_enable <= 1'b0;
                                state      <= ST_FINISH;
                            end
                        end
                    end
                    // two cycles: done shows in the second, busy drops after it
                    ST_FINISH: begin
                        if (!fin_last) begin
                            fin_last <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            fin_last <= 1'b0;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
